// File: rtl/srp_capture_arbiter.sv
// srp_capture_arbiter
// Trigger-based circular capture engine for the 2096x32 SRP sample buffer,
// plus a round-robin arbiter sharing the single RAM port between the
// correlator sample stream (writer) and the readback path (reader).
// Optional feature macro: SRP_WRAP_COUNT_EN adds a saturating 16-bit
// wrap_cnt output that counts ring wraps since the last arm.
module srp_capture_arbiter #(
  parameter int unsigned DEPTH = 2096,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          trigger,
  input  logic [AW-1:0] post_len,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic          wrapped,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_di,
  input  logic [DW-1:0] bram_dout
`ifdef SRP_WRAP_COUNT_EN
  ,
  output logic [15:0]   wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_POST,
    S_DONE
  } state_t;

  typedef enum logic {
    WIN_WRITE,
    WIN_READ
  } win_t;

  state_t        state, state_nxt;
  win_t          last_win;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] post_cnt;
  logic          rd_oor;

  logic wr_elig;
  logic wr_req;
  logic contested;
  logic wr_gnt;
  logic rd_gnt;
  logic rd_in_range;
  logic ptr_at_end;
  logic trig_last;

  // Request qualification and round-robin grant decision
  always_comb begin
    wr_elig     = (state == S_CAPTURE) || (state == S_POST);
    wr_req      = wr_elig && s_valid;
    contested   = wr_req && rd_req;
    s_ready     = wr_elig && (!rd_req || (last_win == WIN_READ));
    rd_ready    = rd_req && (!wr_req || (last_win == WIN_WRITE));
    wr_gnt      = wr_req && s_ready;
    rd_gnt      = rd_req && rd_ready;
    rd_in_range = (rd_addr < AW'(DEPTH));
    ptr_at_end  = (wr_ptr == AW'(DEPTH - 1));
    // A sample accepted in the trigger cycle is the first post-trigger
    // sample, so it consumes one count of post_len.
    trig_last   = (post_len == '0) || (wr_gnt && (post_len == AW'(1)));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; arm restarts capture from any state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (arm) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (arm)          state_nxt = S_CAPTURE;
        else if (trigger) state_nxt = trig_last ? S_DONE : S_POST;
      end
      S_POST: begin
        if (arm)                                   state_nxt = S_CAPTURE;
        else if (wr_gnt && (post_cnt <= AW'(1)))   state_nxt = S_DONE;
      end
      S_DONE: begin
        if (arm) state_nxt = S_CAPTURE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and RAM port drive
  always_comb begin
    busy      = (state == S_CAPTURE) || (state == S_POST);
    done      = (state == S_DONE);
    bram_en   = wr_gnt || (rd_gnt && rd_in_range);
    bram_we   = wr_gnt;
    bram_addr = '0;
    bram_di   = '0;
    if (wr_gnt) begin
      bram_addr = wr_ptr;
      bram_di   = s_data;
    end else if (rd_gnt) begin
      bram_addr = rd_addr;
    end
  end

  // Capture datapath: write pointer, wrap tracking, trigger bookkeeping.
  // A sample granted in the arm cycle still lands at the old pointer; the
  // restart takes effect from the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      wrapped   <= 1'b0;
    end else if (arm) begin
      wr_ptr   <= '0;
      post_cnt <= '0;
      wrapped  <= 1'b0;
    end else begin
      if (wr_gnt) begin
        if (ptr_at_end) begin
          wr_ptr  <= '0;
          wrapped <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      if ((state == S_CAPTURE) && trigger) begin
        trig_addr <= wr_ptr;
        post_cnt  <= (wr_gnt && (post_len != '0)) ? post_len - AW'(1) : post_len;
      end else if ((state == S_POST) && wr_gnt) begin
        post_cnt <= post_cnt - AW'(1);
      end
    end
  end

`ifdef SRP_WRAP_COUNT_EN
  // Saturating count of ring wraps since the last arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            wrap_cnt <= '0;
    else if (arm)                                          wrap_cnt <= '0;
    else if (wr_gnt && ptr_at_end && (wrap_cnt != '1))     wrap_cnt <= wrap_cnt + 16'd1;
  end
`endif

  // Arbiter history: only contested cycles move the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_win <= WIN_READ;
    else if (contested) last_win <= wr_gnt ? WIN_WRITE : WIN_READ;
  end

  // Read response pipeline: valid one cycle after grant, out-of-range flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      rd_oor   <= rd_gnt && !rd_in_range;
    end
  end

  // Read data passthrough; zero for out-of-range or idle cycles
  always_comb begin
    rd_data = (rd_valid && !rd_oor) ? bram_dout : '0;
  end

endmodule

// File: tb/tb_srp_capture_arbiter.sv
// Self-checking bench for srp_capture_arbiter: behavioural RAM, scoreboard
// queues for expected RAM writes and read responses, directed stimulus.
module tb_srp_capture_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          trigger;
  logic [AW-1:0] post_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic          wrapped;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di;
  logic [DW-1:0] bram_dout;
`ifdef SRP_WRAP_COUNT_EN
  logic [15:0]   wrap_cnt;
`endif

  srp_capture_arbiter #(.DEPTH(2096), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .trigger   (trigger),
    .post_len  (post_len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .wrapped   (wrapped),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_di   (bram_di),
    .bram_dout (bram_dout)
`ifdef SRP_WRAP_COUNT_EN
    ,
    .wrap_cnt  (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, one-cycle read latency
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      else         bram_dout <= mem[bram_addr];
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int            total;
  int            bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every RAM write and every read response is checked against the queues
  wr_t           mw;
  logic [DW-1:0] mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en && bram_we) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %h expected none", bram_addr, bram_di);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", 32'(bram_addr), 32'(mw.a));
          chk("wr_data", bram_di, mw.d);
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd_valid: got data %h expected none", rd_data);
        end else begin
          mr = exp_rd.pop_front();
          chk("rd_data", rd_data, mr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int unsigned a, input logic [DW-1:0] d);
    wr_t w;
    w.a = AW'(a);
    w.d = d;
    exp_wr.push_back(w);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    post_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    rd_req = 1'b0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_bram_en", 32'(bram_en), 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // Arm and five samples at addresses 0..4
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data = 32'hA0 + 32'(i);
      push_wr(i, 32'hA0 + 32'(i));
      tick();
    end
    s_valid = 1'b0;
    chk("five_busy", 32'(busy), 1);
    chk("five_wrapped", 32'(wrapped), 0);
    chk("five_done", 32'(done), 0);

    // Contested cycles: W,R,W,R; writes land at 5,6, reads of 0,1
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      rd_req = 1'b1;
      s_data = 32'hB0 + 32'(k);
      rd_addr = AW'(k >> 1);
      #1;
      chk("alt_s_ready", 32'(s_ready), (k % 2 == 0) ? 1 : 0);
      chk("alt_rd_ready", 32'(rd_ready), (k % 2 == 1) ? 1 : 0);
      chk("alt_rd_valid", 32'(rd_valid), (k == 2) ? 1 : 0);
      if (k % 2 == 0) push_wr(5 + (k >> 1), 32'hB0 + 32'(k));
      else            exp_rd.push_back((k == 1) ? 32'hA0 : 32'hA1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    rd_req = 1'b0;
    chk("alt_last_rd_valid", 32'(rd_valid), 1);

    // Trigger with post_len=0 and no sample: DONE next cycle, trig_addr=7
    trigger = 1'b1;
    post_len = '0;
    tick();
    trigger = 1'b0;
    chk("pl0_done", 32'(done), 1);
    chk("pl0_busy", 32'(busy), 0);
    chk("pl0_trig_addr", 32'(trig_addr), 7);
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;
    #1;
    chk("pl0_s_ready", 32'(s_ready), 0);
    chk("pl0_bram_en", 32'(bram_en), 0);
    tick();
    tick();
    s_valid = 1'b0;

    // 2100 samples, trigger on the last with post_len=3, then writes at 4,5
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("rearm_done", 32'(done), 0);
    chk("rearm_wrapped", 32'(wrapped), 0);
    for (int i = 0; i < 2102; i++) begin
      s_valid = 1'b1;
      s_data = 32'h1000_0000 | 32'(i);
      trigger = (i == 2099);
      post_len = 12'd3;
      push_wr(i % 2096, 32'h1000_0000 | 32'(i));
      tick();
      trigger = 1'b0;
      if (i == 2094) chk("wrap_before", 32'(wrapped), 0);
      if (i == 2095) chk("wrap_after", 32'(wrapped), 1);
      if (i == 2099) begin
        chk("trig_addr_3", 32'(trig_addr), 3);
        chk("trig_busy", 32'(busy), 1);
        chk("trig_done", 32'(done), 0);
      end
      if (i == 2100) chk("post_mid_done", 32'(done), 0);
    end
    s_data = 32'hFFFF_FFFF;
    #1;
    chk("post_done", 32'(done), 1);
    chk("post_s_ready", 32'(s_ready), 0);
    chk("post_busy", 32'(busy), 0);
    tick();
    s_valid = 1'b0;

    // Reads in DONE, including the last word and an out-of-range address
    rd_req = 1'b1;
    rd_addr = 12'd2095;
    #1;
    chk("rd2095_ready", 32'(rd_ready), 1);
    chk("rd2095_en", 32'(bram_en), 1);
    exp_rd.push_back(32'h1000_082F);
    tick();
    rd_addr = 12'd2100;
    #1;
    chk("rd2100_ready", 32'(rd_ready), 1);
    chk("rd2100_en", 32'(bram_en), 0);
    exp_rd.push_back(32'h0);
    tick();
    rd_addr = 12'd3;
    exp_rd.push_back(32'h1000_0833);
    tick();
    rd_addr = 12'd5;
    exp_rd.push_back(32'h1000_0835);
    tick();
    rd_req = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of POST
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data = 32'hC0 + 32'(i);
      trigger = (i == 2);
      post_len = 12'd5;
      push_wr(i, 32'hC0 + 32'(i));
      tick();
    end
    trigger = 1'b0;
    s_valid = 1'b0;
    chk("post5_busy", 32'(busy), 1);
    rd_req = 1'b1;
    rd_addr = 12'd1;
    tick();
    rd_req = 1'b0;
    chk("pre_rst_rd_valid", 32'(rd_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_rd_valid", 32'(rd_valid), 0);
    chk("async_rd_data", rd_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("postrst_trig_addr", 32'(trig_addr), 0);
    chk("postrst_busy", 32'(busy), 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = 32'hD0 + 32'(i);
      push_wr(i, 32'hD0 + 32'(i));
      tick();
    end
    s_valid = 1'b0;
    rd_req = 1'b1;
    rd_addr = 12'd1;
    exp_rd.push_back(32'hD1);
    tick();
    rd_req = 1'b0;
    tick();
    tick();

`ifdef SRP_WRAP_COUNT_EN
    // Three full laps from pointer 2 -> three wraps; arm clears the count
    chk("wc_start", 32'(wrap_cnt), 0);
    for (int i = 0; i < 3 * 2096; i++) begin
      s_valid = 1'b1;
      s_data = 32'(i);
      push_wr((i + 2) % 2096, 32'(i));
      tick();
    end
    s_valid = 1'b0;
    chk("wc_three", 32'(wrap_cnt), 3);
    chk("wc_wrapped", 32'(wrapped), 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("wc_cleared", 32'(wrap_cnt), 0);
`endif

    repeat (3) tick();
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
